// File: rtl/amo_sequencer_pkg.sv
// Shared types and constants for the RV64A atomic sequencer.
package amo_sequencer_pkg;
  localparam int AMO_XLEN = 64;
  localparam int AMO_RESV_GRAN = 3;

  localparam logic [2:0] FUNCT3_W = 3'h2;
  localparam logic [2:0] FUNCT3_D = 3'h3;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} amo_state_t;

  typedef enum logic [4:0] {
    AMO_ADD  = 5'b00000,
    AMO_SWAP = 5'b00001,
    AMO_LR   = 5'b00010,
    AMO_SC   = 5'b00011,
    AMO_XOR  = 5'b00100,
    AMO_OR   = 5'b01000,
    AMO_AND  = 5'b01100,
    AMO_MIN  = 5'b10000,
    AMO_MAX  = 5'b10100,
    AMO_MINU = 5'b11000,
    AMO_MAXU = 5'b11100
  } funct5_amo_type_t;

  function automatic logic funct5_legal(input logic [4:0] f);
    case (f)
      AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR,
      AMO_AND, AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: funct5_legal = 1'b1;
      default: funct5_legal = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/amo_sequencer_alu.sv
// Combinational AMO operator: new = op(old, src). Word ops use the low 32 bits of the result.
module amo_alu
  import amo_sequencer_pkg::*;
(
  input  logic [AMO_XLEN-1:0] old_val,
  input  logic [AMO_XLEN-1:0] src_val,
  input  funct5_amo_type_t    funct5,
  input  logic                is_word,
  output logic [AMO_XLEN-1:0] new_val
);
  logic [AMO_XLEN-1:0] a;
  logic [AMO_XLEN-1:0] b;
  logic lt_s;
  logic lt_u;

  // Sign-extending word operands keeps both signed and unsigned 32-bit ordering intact at 64 bits.
  always_comb begin
    a = is_word ? {{32{old_val[31]}}, old_val[31:0]} : old_val;
    b = is_word ? {{32{src_val[31]}}, src_val[31:0]} : src_val;
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    case (funct5)
      AMO_ADD:  new_val = a + b;
      AMO_XOR:  new_val = a ^ b;
      AMO_OR:   new_val = a | b;
      AMO_AND:  new_val = a & b;
      AMO_MIN:  new_val = lt_s ? a : b;
      AMO_MAX:  new_val = lt_s ? b : a;
      AMO_MINU: new_val = lt_u ? a : b;
      AMO_MAXU: new_val = lt_u ? b : a;
      default:  new_val = b;
    endcase
  end
endmodule

// File: rtl/amo_sequencer.sv
// MEM-stage sequencer for LR/SC/AMO as read-modify-write bus transactions; owns the LR reservation.
module amo_sequencer
  import amo_sequencer_pkg::*;
#(
  parameter int XLEN = AMO_XLEN,
  parameter int RESV_GRAN = AMO_RESV_GRAN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [4:0]      req_funct5,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_data,
  input  logic [4:0]      req_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            snoop_st,
  input  logic [XLEN-1:0] snoop_addr,
  input  logic            clear_resv,
  output logic            rsp_valid,
  output logic [4:0]      rsp_rd,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  output logic            busy,
  output amo_state_t      fsm_state
);
  // Handshake: a request is taken on a rising edge where req_valid && req_ready; rsp_valid is a
  // single-cycle pulse with no backpressure; mem_req holds with stable address until mem_ack.
  amo_state_t state, state_nxt;

  funct5_amo_type_t op_f5;
  logic op_word;
  logic [XLEN-1:0] op_addr;
  logic [XLEN-1:0] op_src;
  logic err_q;
  logic resv_valid;
  logic [XLEN-1:RESV_GRAN] resv_gran;

  logic accept, is_word_in, req_err, req_sc, sc_ok;
  logic snoop_hit_req, snoop_hit_op, snoop_hit_resv, lr_done;
  logic [31:0] lane_word;
  logic [XLEN-1:0] rd_val, alu_val, alu_wdata;
  logic unused_bits;

  assign accept     = req_valid && req_ready;
  assign is_word_in = (req_funct3 == FUNCT3_W);
  assign req_err    = !(is_word_in || req_funct3 == FUNCT3_D) || !funct5_legal(req_funct5)
                      || (is_word_in ? (req_addr[1:0] != 2'b0) : (req_addr[2:0] != 3'b0));
  assign req_sc     = (req_funct5 == AMO_SC);

  assign snoop_hit_req  = snoop_st && (snoop_addr[XLEN-1:RESV_GRAN] == req_addr[XLEN-1:RESV_GRAN]);
  assign snoop_hit_op   = snoop_st && (snoop_addr[XLEN-1:RESV_GRAN] == op_addr[XLEN-1:RESV_GRAN]);
  assign snoop_hit_resv = snoop_st && (snoop_addr[XLEN-1:RESV_GRAN] == resv_gran);
  assign sc_ok = resv_valid && (resv_gran == req_addr[XLEN-1:RESV_GRAN])
                 && !clear_resv && !snoop_hit_req;
  assign lr_done = (state == READ) && mem_ack && (op_f5 == AMO_LR);

  assign lane_word = op_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  assign rd_val    = op_word ? {{32{lane_word[31]}}, lane_word} : mem_rdata;
  assign alu_wdata = op_word ? {alu_val[31:0], alu_val[31:0]} : alu_val;
  assign mem_addr  = {op_addr[XLEN-1:3], 3'b0};
  assign unused_bits = ^{op_addr[1:0], snoop_addr[RESV_GRAN-1:0]};

  amo_alu u_alu (
    .old_val(rd_val),
    .src_val(op_src),
    .funct5 (op_f5),
    .is_word(op_word),
    .new_val(alu_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (req_err)     state_nxt = RESP;
        else if (req_sc) state_nxt = sc_ok ? WRITE : RESP;
        else             state_nxt = READ;
      end
      READ:    if (mem_ack) state_nxt = (op_f5 == AMO_LR) ? RESP : WRITE;
      WRITE:   if (mem_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    mem_req   = (state == READ) || (state == WRITE);
    mem_we    = (state == WRITE);
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) && err_q;
    fsm_state = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_f5     <= AMO_ADD;
      op_word   <= 1'b0;
      op_addr   <= '0;
      op_src    <= '0;
      err_q     <= 1'b0;
      rsp_rd    <= '0;
      rsp_data  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (accept) begin
      op_f5     <= funct5_amo_type_t'(req_funct5);
      op_word   <= is_word_in;
      op_addr   <= req_addr;
      op_src    <= req_data;
      err_q     <= req_err;
      rsp_rd    <= req_rd;
      rsp_data  <= (!req_err && req_sc && !sc_ok) ? {{(XLEN-1){1'b0}}, 1'b1} : '0;
      mem_wdata <= is_word_in ? {req_data[31:0], req_data[31:0]} : req_data;
      mem_wstrb <= !is_word_in ? 8'hFF : (req_addr[2] ? 8'hF0 : 8'h0F);
    end else if (state == READ && mem_ack) begin
      rsp_data  <= rd_val;
      mem_wdata <= alu_wdata;
    end
  end

  // A snoop landing in the same cycle as the LR read ack wins over the new reservation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_valid <= 1'b0;
      resv_gran  <= '0;
    end else if (lr_done) begin
      resv_valid <= !(clear_resv || snoop_hit_op);
      resv_gran  <= op_addr[XLEN-1:RESV_GRAN];
    end else if (clear_resv || snoop_hit_resv || (accept && req_sc)) begin
      resv_valid <= 1'b0;
    end
  end
endmodule
